// File: rtl/execute_stage.sv
// Execute stage of the multi-cycle MIPS core: single-cycle ALU plus an iterative
// unsigned multiply/divide unit that holds the sequencer via ex_busy.
module execute_stage #(
  parameter int         WIDTH    = 32,
  parameter logic [5:0] EX_STATE = 6'b001000,
  parameter int         ITERS    = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [5:0]       state,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] SignImm,
  input  logic             ALUSrc,
  input  logic [3:0]       ALUControl,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] PC_next,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] WriteData,
  output logic             Zero,
  output logic [WIDTH-1:0] PC_beq,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             ex_busy,
  output logic             ex_done
);

  localparam int CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} fsm_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0110, OP_SLT  = 4'b0111, OP_SLL  = 4'b1000, OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010, OP_MULTU = 4'b1011, OP_NOR = 4'b1100, OP_DIVU = 4'b1101,
    OP_MFHI = 4'b1110, OP_MFLO = 4'b1111
  } alu_op_e;

  fsm_e             fsm_q;
  logic [CW-1:0]    count_q;
  logic             served_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic [WIDTH-1:0] alu_result_q, write_data_q, pc_beq_q, hi_q, lo_q;
  logic             zero_q, ex_busy_q, ex_done_q;

  alu_op_e          op;
  logic [WIDTH-1:0] op_a, op_b, alu_d;
  logic             in_ex, start;

  assign op    = alu_op_e'(ALUControl);
  assign op_a  = ReadData1;
  assign op_b  = ALUSrc ? SignImm : ReadData2;
  assign in_ex = (state == EX_STATE);
  assign start = in_ex && !served_q && (fsm_q == IDLE);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    alu_d = '0;
    case (op)
      OP_AND:  alu_d = op_a & op_b;
      OP_OR:   alu_d = op_a | op_b;
      OP_ADD:  alu_d = op_a + op_b;
      OP_XOR:  alu_d = op_a ^ op_b;
      OP_SUB:  alu_d = op_a - op_b;
      OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_NOR:  alu_d = ~(op_a | op_b);
      OP_SLL:  alu_d = op_b << shamt;
      OP_SRL:  alu_d = op_b >> shamt;
      OP_SRA:  alu_d = $signed(op_b) >>> shamt;
      OP_MFHI: alu_d = hi_q;
      OP_MFLO: alu_d = lo_q;
      default: alu_d = '0;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide on {acc_hi, acc_lo}.
  logic [WIDTH:0]   mul_sum, div_shift;
  logic             div_ge, div_zero, finishing;
  logic [WIDTH-1:0] iter_hi_d, iter_lo_d, fin_hi_d, fin_lo_d;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (fsm_q == MUL) begin
      iter_hi_d = mul_sum[WIDTH:1];
      iter_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      iter_hi_d = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
      iter_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
    end
    div_zero  = (fsm_q == DIV) && (opnd_q == '0);
    finishing = div_zero || (count_q == LAST);
    fin_hi_d  = div_zero ? acc_lo_q : iter_hi_d;
    fin_lo_d  = div_zero ? '1 : iter_lo_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // update from the same pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fsm_q        <= IDLE;
      count_q      <= '0;
      served_q     <= 1'b0;
      acc_hi_q     <= '0;
      acc_lo_q     <= '0;
      opnd_q       <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_beq_q     <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      zero_q       <= 1'b0;
      ex_busy_q    <= 1'b0;
      ex_done_q    <= 1'b0;
    end else begin
      ex_done_q <= 1'b0;
      if (!in_ex) served_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start && (op == OP_MULTU || op == OP_DIVU)) begin
            acc_hi_q  <= '0;
            acc_lo_q  <= op_a;
            opnd_q    <= op_b;
            count_q   <= '0;
            ex_busy_q <= 1'b1;
            fsm_q     <= (op == OP_MULTU) ? MUL : DIV;
          end else if (start) begin
            alu_result_q <= alu_d;
            zero_q       <= (alu_d == '0);
            pc_beq_q     <= PC_next + SignImm;
            write_data_q <= ReadData2;
            ex_done_q    <= 1'b1;
            served_q     <= 1'b1;
          end
        end
        MUL, DIV: begin
          if (!in_ex) begin
            // Sequencer moved on: abandon silently, architectural state untouched.
            fsm_q     <= IDLE;
            ex_busy_q <= 1'b0;
          end else if (finishing) begin
            hi_q         <= fin_hi_d;
            lo_q         <= fin_lo_d;
            alu_result_q <= fin_lo_d;
            zero_q       <= (fin_lo_d == '0);
            pc_beq_q     <= PC_next + SignImm;
            write_data_q <= ReadData2;
            ex_busy_q    <= 1'b0;
            ex_done_q    <= 1'b1;
            served_q     <= 1'b1;
            fsm_q        <= DONE;
          end else begin
            acc_hi_q <= iter_hi_d;
            acc_lo_q <= iter_lo_d;
            count_q  <= count_q + 1'b1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign ALUResult = alu_result_q;
  assign WriteData = write_data_q;
  assign Zero      = zero_q;
  assign PC_beq    = pc_beq_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign ex_busy   = ex_busy_q;
  assign ex_done   = ex_done_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: hand-computed vectors checked with immediate assertions.
module tb_execute_stage;

  localparam logic [5:0] EX    = 6'b001000;
  localparam logic [5:0] OTHER = 6'b010000;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [5:0]  state;
  logic [31:0] ReadData1, ReadData2, SignImm, PC_next;
  logic        ALUSrc;
  logic [3:0]  ALUControl;
  logic [4:0]  shamt;
  logic [31:0] ALUResult, WriteData, PC_beq, HI, LO;
  logic        Zero, ex_busy, ex_done;

  int n_vec = 0;
  int n_bad = 0;
  int overlap = 0;

  execute_stage dut (
    .CLK(CLK), .RST_N(RST_N), .state(state),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .SignImm(SignImm),
    .ALUSrc(ALUSrc), .ALUControl(ALUControl), .shamt(shamt), .PC_next(PC_next),
    .ALUResult(ALUResult), .WriteData(WriteData), .Zero(Zero), .PC_beq(PC_beq),
    .HI(HI), .LO(LO), .ex_busy(ex_busy), .ex_done(ex_done)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (ex_busy && ex_done) overlap++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic leave_ex();
    state = OTHER;
    tick();
  endtask

  task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src, input logic [4:0] sh,
                       input logic [31:0] pc);
    ALUControl = ctrl; ReadData1 = a; ReadData2 = b; SignImm = imm;
    ALUSrc = src; shamt = sh; PC_next = pc; state = EX;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu"},  ALUResult, 32'h0);
    check({tag, "_wd"},   WriteData, 32'h0);
    check({tag, "_zero"}, {31'b0, Zero}, 32'h0);
    check({tag, "_pcb"},  PC_beq, 32'h0);
    check({tag, "_hi"},   HI, 32'h0);
    check({tag, "_lo"},   LO, 32'h0);
    check({tag, "_busy"}, {31'b0, ex_busy}, 32'h0);
    check({tag, "_done"}, {31'b0, ex_done}, 32'h0);
  endtask

  initial begin
    int n;
    int dones;
    RST_N = 1'b0; state = OTHER; ReadData1 = '0; ReadData2 = '0; SignImm = '0;
    PC_next = '0; ALUSrc = 1'b0; ALUControl = '0; shamt = '0;
    repeat (2) tick();
    check_all_zero("reset");
    RST_N = 1'b1;

    // ADD 5+7, single cycle, one done pulse
    issue(4'b0010, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check("add_res", ALUResult, 32'd12);
    check("add_zero", {31'b0, Zero}, 32'd0);
    check("add_done", {31'b0, ex_done}, 32'd1);
    tick();
    check("add_done_once", {31'b0, ex_done}, 32'd0);
    check("add_hold", ALUResult, 32'd12);
    leave_ex();

    // SUB equal operands: Zero and branch target
    issue(4'b0110, 32'h1234, 32'h1234, 32'hFFFF_FFFD, 1'b0, 5'd0, 32'd10);
    tick();
    check("sub_res", ALUResult, 32'd0);
    check("sub_zero", {31'b0, Zero}, 32'd1);
    check("sub_pcbeq", PC_beq, 32'd7);
    check("sub_wd", WriteData, 32'h1234);
    leave_ex();

    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check("slt_res", ALUResult, 32'd1);
    leave_ex();

    issue(4'b1010, 32'd0, 32'h8000_0000, 32'd0, 1'b0, 5'd4, 32'd0);
    tick();
    check("sra_res", ALUResult, 32'hF800_0000);
    leave_ex();

    issue(4'b1001, 32'd0, 32'h8000_0000, 32'd0, 1'b0, 5'd4, 32'd0);
    tick();
    check("srl_res", ALUResult, 32'h0800_0000);
    leave_ex();

    issue(4'b0010, 32'd1, 32'h999, 32'h10, 1'b1, 5'd0, 32'd0);
    tick();
    check("imm_res", ALUResult, 32'h11);
    check("imm_wd", WriteData, 32'h999);
    leave_ex();

    issue(4'b1100, 32'h0, 32'hF0F0_F0F0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check("nor_res", ALUResult, 32'h0F0F_0F0F);
    leave_ex();

    issue(4'b0100, 32'h55, 32'h66, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check("undef_res", ALUResult, 32'd0);
    check("undef_zero", {31'b0, Zero}, 32'd1);
    leave_ex();

    // MULTU 0xFFFFFFFF * 2
    issue(4'b1011, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    n = 0;
    while (ex_busy && n < 100) begin n++; tick(); end
    check("mul_busy_cycles", n, 32'd32);
    check("mul_done", {31'b0, ex_done}, 32'd1);
    check("mul_hi", HI, 32'd1);
    check("mul_lo", LO, 32'hFFFF_FFFE);
    check("mul_alu", ALUResult, 32'hFFFF_FFFE);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ex_done || ex_busy) dones++;
    end
    check("mul_no_restart", dones, 32'd0);
    leave_ex();

    // DIVU 100/7
    issue(4'b1101, 32'd100, 32'd7, 32'd0, 1'b0, 5'd0, 32'd0);
    n = 0;
    do begin tick(); n++; end while (!ex_done && n < 100);
    check("div_edges", n, 32'd33);
    check("div_lo", LO, 32'd14);
    check("div_hi", HI, 32'd2);
    check("div_alu", ALUResult, 32'd14);
    leave_ex();

    // DIVU by zero
    issue(4'b1101, 32'd9, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    n = 0;
    do begin tick(); n++; end while (!ex_done && n < 100);
    check("div0_edges", n, 32'd2);
    check("div0_hi", HI, 32'd9);
    check("div0_lo", LO, 32'hFFFF_FFFF);
    leave_ex();

    issue(4'b1110, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check("mfhi", ALUResult, 32'd9);
    leave_ex();
    issue(4'b1111, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check("mflo", ALUResult, 32'hFFFF_FFFF);
    leave_ex();

    // Abort at iteration 10
    issue(4'b1011, 32'd3, 32'd5, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (10) tick();
    check("abort_busy_before", {31'b0, ex_busy}, 32'd1);
    leave_ex();
    check("abort_busy", {31'b0, ex_busy}, 32'd0);
    check("abort_done", {31'b0, ex_done}, 32'd0);
    check("abort_hi", HI, 32'd9);
    check("abort_lo", LO, 32'hFFFF_FFFF);
    check("abort_alu", ALUResult, 32'hFFFF_FFFF);
    dones = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (ex_done) dones++; end
    check("abort_no_done", dones, 32'd0);

    // A fresh multiply after the abort runs to completion
    issue(4'b1011, 32'd3, 32'd5, 32'd0, 1'b0, 5'd0, 32'd0);
    n = 0;
    do begin tick(); n++; end while (!ex_done && n < 100);
    check("mul2_edges", n, 32'd33);
    check("mul2_lo", LO, 32'd15);
    check("mul2_hi", HI, 32'd0);
    leave_ex();

    // Reset mid-cycle at iteration 5
    issue(4'b1101, 32'd100, 32'd7, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (6) tick();
    #3 RST_N = 1'b0;
    #1 check_all_zero("midreset");
    state = OTHER;
    #2 RST_N = 1'b1;
    tick();
    issue(4'b0010, 32'd1, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check("post_reset_add", ALUResult, 32'd2);
    check("post_reset_done", {31'b0, ex_done}, 32'd1);
    leave_ex();

    check("busy_done_overlap", overlap, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
